sync_data_event_queue: RTL and testbench

Fast-domain consumer placed directly after the slow-to-fast data synchronizer. Samples the synchronized multi-bit bus every `clk` cycle and qualifies a new value only after it has held for a configurable number of cycles. Each qualified change is pushed as an event into a small first-word-fall-through FIFO. Game logic drains the FIFO with a valid/ready handshake, so no value change is missed while the consumer is busy.

---
 rtl/sync_data_event_queue.sv | 172 +++++++++++++++++
 tb/tb_sync_data_event_queue.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_data_event_queue.sv
// sync_data_event_queue
//
// Fast-domain consumer that sits right after the slow-to-fast data
// synchronizer. The synchronized bus is sampled every clk edge. A value is
// qualified once it has been seen on STABLE_CYCLES consecutive edges, and
// every qualified change is queued as one event in a small
// first-word-fall-through FIFO. Game logic drains the FIFO through a
// valid/ready handshake.
//
// Optional feature macro: SYNC_EVENT_STABLE_FILTER_EN
//   defined   : stability filter active (STABLE_CYCLES equal samples).
//   undefined : no filter; every sampled change is queued one edge after it
//               is sampled, the same as STABLE_CYCLES = 1.
//
// Handshake: out_valid is high whenever the FIFO holds at least one event,
// and out_data is the oldest event. The head is consumed on any clk edge
// where out_valid && out_ready. out_ready is ignored while out_valid is low.
// The producer side (the qualifier) never waits: if the FIFO is full and no
// pop happens on the same edge, the event is dropped and the sticky
// overflow flag is raised.

module sync_data_event_queue #(
  parameter int data_bus_size = 5,
  parameter int STABLE_CYCLES = 3,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [data_bus_size-1:0]      in_data_sync,
  output logic [data_bus_size-1:0]      out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  input  logic                          overflow_clr
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  // Reject configurations the pointer arithmetic cannot handle.
  if (STABLE_CYCLES < 1 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_cfg_check
    $error("sync_data_event_queue: illegal STABLE_CYCLES or FIFO_DEPTH");
  end

  // ---------------------------------------------------------------------
  // Sample stage
  // ---------------------------------------------------------------------
  logic [data_bus_size-1:0] s_reg;
  logic                     stable;

  // Track the most recently sampled bus value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_reg <= '0;
    end else if (in_data_sync != s_reg) begin
      s_reg <= in_data_sync;
    end
  end

`ifdef SYNC_EVENT_STABLE_FILTER_EN
  localparam int SCW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [SCW-1:0] STAB_MAX = SCW'(STABLE_CYCLES - 1);

  logic [SCW-1:0] stab_cnt;

  // Count consecutive equal samples; restart on change, saturate at the top.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stab_cnt <= '0;
    end else if (in_data_sync != s_reg) begin
      stab_cnt <= '0;
    end else if (stab_cnt != STAB_MAX) begin
      stab_cnt <= stab_cnt + 1'b1;
    end
  end

  assign stable = (stab_cnt == STAB_MAX);
`else
  // Without the filter every sampled value counts as settled.
  assign stable = 1'b1;
`endif

  // ---------------------------------------------------------------------
  // Qualification
  // ---------------------------------------------------------------------
  logic [data_bus_size-1:0] last_val;
  logic                     push;

  // One attempt per settled value that differs from the last one queued.
  assign push = stable && (s_reg != last_val);

  // Remember the value of every push attempt, even a dropped one, so the
  // same value never produces a second event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_val <= '0;
    end else if (push) begin
      last_val <= s_reg;
    end
  end

  // ---------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------
  logic [data_bus_size-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;
  logic                     full;
  logic                     pop;
  logic                     wr_en;
  logic                     drop;

  assign out_valid = (count != '0);
  assign full      = (count == DEPTH_C);
  assign pop       = out_valid && out_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign wr_en     = push && (!full || pop);
  assign drop      = push && full && !pop;

  // Head is forced to zero while empty so reset shows zero immediately.
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= s_reg;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Occupancy: up on write, down on pop, unchanged when both happen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else begin
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky drop flag; a new drop on the clearing edge keeps it set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sync_data_event_queue.sv
// Testbench for sync_data_event_queue: table-driven latency vectors,
// hand-written corner sequences and randomized traffic, all checked against
// a sample-history reference model kept in the bench.

module tb_sync_data_event_queue;

  localparam int W     = 5;
  localparam int SC    = 3;
  localparam int DEPTH = 4;
`ifdef SYNC_EVENT_STABLE_FILTER_EN
  localparam int EFF_SC = SC;
`else
  localparam int EFF_SC = 1;
`endif

  // ---------------- clock / reset ----------------
  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [W-1:0]              in_data_sync;
  logic [W-1:0]              out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [$clog2(DEPTH):0]    count;
  logic                      overflow;
  logic                      overflow_clr;

  always #5 clk = ~clk;

  sync_data_event_queue #(
    .data_bus_size (W),
    .STABLE_CYCLES (SC),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_data_sync (in_data_sync),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .count        (count),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A value qualifies on an edge when the last EFF_SC samples (reset counts
  // as one sample of zero) all equal it and it differs from the last value
  // that qualified.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_last;
  logic [W-1:0] exp_q[$];
  bit           m_ovf;

  function automatic void m_reset();
    exp_q.delete();
    hist.delete();
    hist.push_back('0);
    m_last = '0;
    m_ovf  = 1'b0;
  endfunction

  function automatic bit qualifies(output logic [W-1:0] v);
    v = hist[hist.size()-1];
    if (hist.size() < EFF_SC) return 1'b0;
    for (int k = 1; k <= EFF_SC; k++)
      if (hist[hist.size()-k] != v) return 1'b0;
    return (v != m_last);
  endfunction

  function automatic void model_edge(input logic [W-1:0] d, input bit r, input bit c);
    logic [W-1:0] v;
    bit           q, p, was_full, dropped;
    q        = qualifies(v);
    dropped  = 1'b0;
    if (q) m_last = v;
    p        = (exp_q.size() > 0) && r;
    was_full = (exp_q.size() == DEPTH);
    if (p) void'(exp_q.pop_front());
    if (q) begin
      if (!was_full || p) exp_q.push_back(v);
      else dropped = 1'b1;
    end
    if (c) m_ovf = 1'b0;
    if (dropped) m_ovf = 1'b1;
    hist.push_back(d);
    if (hist.size() > EFF_SC) void'(hist.pop_front());
  endfunction

  task automatic check_model();
    chk("model_valid", int'(out_valid), int'(exp_q.size() > 0));
    chk("model_count", int'(count), exp_q.size());
    chk("model_ovf", int'(overflow), int'(m_ovf));
    if (exp_q.size() > 0) chk("model_data", int'(out_data), int'(exp_q[0]));
  endtask

  // ---------------- driver tasks ----------------
  // Apply inputs, take one edge, update the model, check 1 time unit later.
  task automatic cycle(input logic [W-1:0] d, input bit r, input bit c);
    in_data_sync = d;
    out_ready    = r;
    overflow_clr = c;
    @(posedge clk);
    model_edge(d, r, c);
    #1;
    check_model();
  endtask

  // Hold one value long enough to be queued.
  task automatic settle(input logic [W-1:0] d, input bit r);
    repeat (EFF_SC + 1) cycle(d, r, 1'b0);
  endtask

  // Asynchronous reset away from the clock edge; outputs must clear at once.
  task automatic do_reset(input logic [W-1:0] d);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_data", int'(out_data), 0);
    m_reset();
    in_data_sync = d;
    out_ready    = 1'b0;
    overflow_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Drain with out_ready high, collecting each accepted head.
  logic [W-1:0] got_q[$];
  task automatic drain(input logic [W-1:0] d, input int max_cycles);
    got_q.delete();
    for (int k = 0; k < max_cycles; k++) begin
      if (out_valid) got_q.push_back(out_data);
      cycle(d, 1'b1, 1'b0);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [W-1:0] din;
    bit           rdy;
    bit           exp_valid;
    logic [W-1:0] exp_data;
    int           exp_count;
  } vec_t;

  vec_t tbl[8];

  logic [W-1:0] exp_order[$];

  initial begin
    int n_valid;
    int cyc;
    logic [W-1:0] d;
    int hold;
    bit r;

    for (int i = 0; i < 8; i++) begin
      tbl[i].din       = W'(5);
      tbl[i].rdy       = 1'b1;
      tbl[i].exp_valid = (i == EFF_SC);
      tbl[i].exp_data  = W'(5);
      tbl[i].exp_count = (i == EFF_SC) ? 1 : 0;
    end

    // Reset at time zero, outputs checked with no clock edge yet.
    reset_n      = 1'b0;
    in_data_sync = '0;
    out_ready    = 1'b0;
    overflow_clr = 1'b0;
    m_reset();
    #3;
    chk("init_valid", int'(out_valid), 0);
    chk("init_count", int'(count), 0);
    chk("init_data", int'(out_data), 0);
    chk("init_ovf", int'(overflow), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Release with input 0: no event for 20 cycles.
    n_valid = 0;
    for (int i = 0; i < 20; i++) begin
      cycle('0, 1'b1, 1'b0);
      if (out_valid || count != 0 || overflow) n_valid++;
    end
    chk("zero_after_reset", n_valid, 0);

    // Step 0->5 with out_ready=1: one-cycle valid after edge EFF_SC.
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].din, tbl[i].rdy, 1'b0);
      chk($sformatf("step_valid[%0d]", i), int'(out_valid), int'(tbl[i].exp_valid));
      chk($sformatf("step_count[%0d]", i), int'(count), tbl[i].exp_count);
      if (tbl[i].exp_valid)
        chk($sformatf("step_data[%0d]", i), int'(out_data), int'(tbl[i].exp_data));
    end

    // Glitch 0->7 for two cycles then back to 0.
    do_reset('0);
    n_valid = 0;
    for (int i = 0; i < 8; i++) begin
      cycle((i < 2) ? W'(7) : W'(0), 1'b1, 1'b0);
      if (out_valid) n_valid++;
    end
    chk("glitch_events", n_valid, (EFF_SC > 2) ? 0 : 2);

    // Overflow: five settled changes with no consumer.
    do_reset('0);
    for (int v = 1; v <= 5; v++) settle(W'(v), 1'b0);
    chk("ovf_count", int'(count), DEPTH);
    chk("ovf_flag", int'(overflow), 1);
    drain(W'(5), 10);
    chk("ovf_drain_len", got_q.size(), 4);
    for (int i = 0; i < got_q.size() && i < 4; i++)
      chk($sformatf("ovf_drain[%0d]", i), int'(got_q[i]), i + 1);
    chk("ovf_sticky", int'(overflow), 1);

    // Full FIFO with push and pop on the same edge.
    do_reset('0);
    for (int v = 1; v <= 4; v++) settle(W'(v), 1'b0);
    for (int j = 0; j <= EFF_SC; j++) cycle(W'(9), (j == EFF_SC), 1'b0);
    chk("fullpp_count", int'(count), DEPTH);
    chk("fullpp_ovf", int'(overflow), 0);
    settle(W'(10), 1'b0);
    chk("fullpp_drop_ovf", int'(overflow), 1);
    cycle(W'(10), 1'b0, 1'b1);
    chk("ovf_clr", int'(overflow), 0);
    for (int j = 0; j <= EFF_SC; j++) cycle(W'(11), 1'b0, (j == EFF_SC));
    chk("ovf_set_wins", int'(overflow), 1);
    cycle(W'(11), 1'b0, 1'b1);
    exp_order = '{W'(2), W'(3), W'(4), W'(9)};
    drain(W'(11), 10);
    chk("fullpp_drain_len", got_q.size(), 4);
    for (int i = 0; i < got_q.size() && i < 4; i++)
      chk($sformatf("fullpp_drain[%0d]", i), int'(got_q[i]), int'(exp_order[i]));

    // Reset mid-drain with three events queued; then one event for input 4.
    do_reset('0);
    for (int v = 1; v <= 4; v++) settle(W'(v), 1'b0);
    cycle(W'(4), 1'b1, 1'b0);
    chk("middrain_count", int'(count), 3);
    do_reset(W'(4));
    for (int i = 0; i < 3 * EFF_SC + 4; i++) cycle(W'(4), 1'b0, 1'b0);
    chk("post_reset_count", int'(count), 1);
    chk("post_reset_data", int'(out_data), 4);

    // Randomized traffic against the model.
    do_reset('0);
    cyc = 0;
    while (cyc < 3000) begin
      d    = W'($urandom_range(0, 3));
      hold = $urandom_range(1, EFF_SC + 2);
      for (int h = 0; h < hold; h++) begin
        if (((cyc / 250) % 2) == 1) r = ($urandom_range(0, 1) == 1);
        else r = ($urandom_range(0, 5) == 0);
        cycle(d, r, ($urandom_range(0, 19) == 0));
        cyc++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #500000;
    n_fail++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
